// File: rtl/wts_key_pkg.sv
// ---------------------------------------------------------------------------
// wts_key_pkg
// Shared definitions for the key event scheduler:
//   key_code_t      - per-channel pending event code (NONE/ON/RELEASE/OFF)
//   NUM_CH          - number of sound channels served by the scheduler
//   NOP_SLOT        - slot index on which no channel is serviced
//   resolve_request - folds one channel's three request strobes into a code
// ---------------------------------------------------------------------------
package wts_key_pkg;

  localparam int NUM_CH   = 5;
  localparam int NOP_SLOT = 5;

  typedef enum logic [1:0] {
    KEY_NONE    = 2'd0,
    KEY_ON      = 2'd1,
    KEY_RELEASE = 2'd2,
    KEY_OFF     = 2'd3
  } key_code_t;

  // Key-off is the safest action, so it beats key-on, which beats release.
  function automatic key_code_t resolve_request(input logic on_req,
                                                input logic release_req,
                                                input logic off_req);
    key_code_t result;
    result = KEY_NONE;
    if (off_req) begin
      result = KEY_OFF;
    end else if (on_req) begin
      result = KEY_ON;
    end else if (release_req) begin
      result = KEY_RELEASE;
    end
    return result;
  endfunction

endpackage

// File: rtl/wts_key_event_slot.sv
// ---------------------------------------------------------------------------
// wts_key_event_slot
// Holds the pending key event of one channel until the slot sequencer
// reaches that channel. Optional sticky overrun flag when the
// WTS_KEY_OVERRUN_EN macro is defined.
// Ports:
//   clk, nreset   - clock, asynchronous active-low reset
//   consume       - this edge is the channel's enabled slot edge
//   on_req        - one-cycle key-on request
//   release_req   - one-cycle key-release request
//   off_req       - one-cycle key-off request
//   overrun_clr   - clears the sticky overrun flag
//   code          - registered pending event code
//   overrun       - sticky overrun flag (constant 0 without the macro)
// ---------------------------------------------------------------------------
module wts_key_event_slot
  import wts_key_pkg::*;
(
  input  logic      clk,
  input  logic      nreset,
  input  logic      consume,
  input  logic      on_req,
  input  logic      release_req,
  input  logic      off_req,
  input  logic      overrun_clr,
  output key_code_t code,
  output logic      overrun
);

  key_code_t req_code;
  key_code_t code_next;
  logic      any_req;

  // A fresh request always lands in the register, even on the consuming
  // edge: the old code is what the envelope generator just took, the new
  // one waits for the next visit of this slot.
  always_comb begin
    req_code  = resolve_request(on_req, release_req, off_req);
    any_req   = (req_code != KEY_NONE);
    code_next = code;
    if (any_req) begin
      code_next = req_code;
    end else if (consume) begin
      code_next = KEY_NONE;
    end
  end

  // Pending code register; reset discards anything not yet consumed.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      code <= KEY_NONE;
    end else begin
      code <= code_next;
    end
  end

`ifdef WTS_KEY_OVERRUN_EN
  logic overrun_set;

  // An overwrite only counts as lost when the old code was not being taken
  // on that same edge.
  assign overrun_set = any_req && (code != KEY_NONE) && !consume;

  // Sticky flag; a set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end
`else
  logic unused_overrun_clr;

  assign unused_overrun_clr = overrun_clr;
  assign overrun            = 1'b0;
`endif

endmodule

// File: rtl/wts_key_event_scheduler.sv
// ---------------------------------------------------------------------------
// wts_key_event_scheduler
// Time-slot scheduler that parks key on/release/off requests per channel and
// presents them to the envelope generator while the slot counter points at
// that channel. Slots 0..4 are channels A..E, slot 5 is a no-op slot.
// Optional feature macro: WTS_KEY_OVERRUN_EN (sticky per-channel overrun).
// Ports:
//   clk, nreset          - clock, asynchronous active-low reset
//   enable               - advances the slot counter
//   key_on_req[4:0]      - one-cycle key-on request, bit0=A .. bit4=E
//   key_release_req[4:0] - one-cycle key-release request
//   key_off_req[4:0]     - one-cycle key-off request
//   overrun_clr[4:0]     - sticky overrun clear
//   active[2:0]          - current slot index
//   ch_x_key_*           - pending event level per channel
//   pending[4:0]         - channel has an unconsumed event
//   overrun[4:0]         - sticky overrun flags
// ---------------------------------------------------------------------------
module wts_key_event_scheduler
  import wts_key_pkg::*;
#(
  parameter int NUM_SLOT = 6
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] key_on_req,
  input  logic [NUM_CH-1:0] key_release_req,
  input  logic [NUM_CH-1:0] key_off_req,
  input  logic [NUM_CH-1:0] overrun_clr,
  output logic [2:0]        active,
  output logic              ch_a_key_on,
  output logic              ch_a_key_release,
  output logic              ch_a_key_off,
  output logic              ch_b_key_on,
  output logic              ch_b_key_release,
  output logic              ch_b_key_off,
  output logic              ch_c_key_on,
  output logic              ch_c_key_release,
  output logic              ch_c_key_off,
  output logic              ch_d_key_on,
  output logic              ch_d_key_release,
  output logic              ch_d_key_off,
  output logic              ch_e_key_on,
  output logic              ch_e_key_release,
  output logic              ch_e_key_off,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun
);

  localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOT - 1);

  key_code_t         code [NUM_CH];
  logic [NUM_CH-1:0] consume;

  // Round-robin slot counter; after reset the first enabled edge leaves
  // slot 0.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      active <= '0;
    end else if (enable) begin
      active <= (active == LAST_SLOT) ? 3'd0 : active + 3'd1;
    end
  end

  // The no-op slot never matches a channel, so nothing is consumed there.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign consume[n] = enable && (active == 3'(n)) && (active != 3'(NOP_SLOT));
    assign pending[n] = (code[n] != KEY_NONE);

    wts_key_event_slot u_slot (
      .clk         (clk),
      .nreset      (nreset),
      .consume     (consume[n]),
      .on_req      (key_on_req[n]),
      .release_req (key_release_req[n]),
      .off_req     (key_off_req[n]),
      .overrun_clr (overrun_clr[n]),
      .code        (code[n]),
      .overrun     (overrun[n])
    );
  end

  // Decoded per-channel levels; a single code guarantees one-hot-or-zero.
  assign ch_a_key_on      = (code[0] == KEY_ON);
  assign ch_a_key_release = (code[0] == KEY_RELEASE);
  assign ch_a_key_off     = (code[0] == KEY_OFF);
  assign ch_b_key_on      = (code[1] == KEY_ON);
  assign ch_b_key_release = (code[1] == KEY_RELEASE);
  assign ch_b_key_off     = (code[1] == KEY_OFF);
  assign ch_c_key_on      = (code[2] == KEY_ON);
  assign ch_c_key_release = (code[2] == KEY_RELEASE);
  assign ch_c_key_off     = (code[2] == KEY_OFF);
  assign ch_d_key_on      = (code[3] == KEY_ON);
  assign ch_d_key_release = (code[3] == KEY_RELEASE);
  assign ch_d_key_off     = (code[3] == KEY_OFF);
  assign ch_e_key_on      = (code[4] == KEY_ON);
  assign ch_e_key_release = (code[4] == KEY_RELEASE);
  assign ch_e_key_off     = (code[4] == KEY_OFF);

endmodule

// File: tb/tb_wts_key_event_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wts_key_event_scheduler
// Directed scenarios with literal expectations followed by randomized
// traffic, all compared every cycle against a behavioural scheduler model.
// ---------------------------------------------------------------------------
module tb_wts_key_event_scheduler;

`ifdef WTS_KEY_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        enable = 1'b0;
  logic [4:0]  key_on_req = '0;
  logic [4:0]  key_release_req = '0;
  logic [4:0]  key_off_req = '0;
  logic [4:0]  overrun_clr = '0;
  logic [2:0]  active;
  logic        ch_a_key_on, ch_a_key_release, ch_a_key_off;
  logic        ch_b_key_on, ch_b_key_release, ch_b_key_off;
  logic        ch_c_key_on, ch_c_key_release, ch_c_key_off;
  logic        ch_d_key_on, ch_d_key_release, ch_d_key_off;
  logic        ch_e_key_on, ch_e_key_release, ch_e_key_off;
  logic [4:0]  pending;
  logic [4:0]  overrun;
  logic [14:0] dut_keys;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: slot number, per-channel code (0 none, 1 on, 2 release,
  // 3 off) and sticky overrun bits.
  int m_slot;
  int m_code [5];
  bit m_ovr  [5];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  wts_key_event_scheduler #(.NUM_SLOT(6)) dut (
    .clk              (clk),
    .nreset           (nreset),
    .enable           (enable),
    .key_on_req       (key_on_req),
    .key_release_req  (key_release_req),
    .key_off_req      (key_off_req),
    .overrun_clr      (overrun_clr),
    .active           (active),
    .ch_a_key_on      (ch_a_key_on),
    .ch_a_key_release (ch_a_key_release),
    .ch_a_key_off     (ch_a_key_off),
    .ch_b_key_on      (ch_b_key_on),
    .ch_b_key_release (ch_b_key_release),
    .ch_b_key_off     (ch_b_key_off),
    .ch_c_key_on      (ch_c_key_on),
    .ch_c_key_release (ch_c_key_release),
    .ch_c_key_off     (ch_c_key_off),
    .ch_d_key_on      (ch_d_key_on),
    .ch_d_key_release (ch_d_key_release),
    .ch_d_key_off     (ch_d_key_off),
    .ch_e_key_on      (ch_e_key_on),
    .ch_e_key_release (ch_e_key_release),
    .ch_e_key_off     (ch_e_key_off),
    .pending          (pending),
    .overrun          (overrun)
  );

  // Key levels packed three per channel: on, release, off from low bit up.
  assign dut_keys = {ch_e_key_off, ch_e_key_release, ch_e_key_on,
                     ch_d_key_off, ch_d_key_release, ch_d_key_on,
                     ch_c_key_off, ch_c_key_release, ch_c_key_on,
                     ch_b_key_off, ch_b_key_release, ch_b_key_on,
                     ch_a_key_off, ch_a_key_release, ch_a_key_on};

  // Expected key levels straight from the model's per-channel codes.
  function automatic logic [14:0] model_keys();
    logic [14:0] k;
    k = '0;
    for (int n = 0; n < 5; n++) begin
      if (m_code[n] != 0) k[3*n + m_code[n] - 1] = 1'b1;
    end
    return k;
  endfunction

  function automatic logic [4:0] model_pending();
    logic [4:0] p;
    p = '0;
    for (int n = 0; n < 5; n++) p[n] = (m_code[n] != 0);
    return p;
  endfunction

  function automatic logic [4:0] model_ovr();
    logic [4:0] o;
    o = '0;
    for (int n = 0; n < 5; n++) o[n] = m_ovr[n];
    return o;
  endfunction

  function automatic logic [4:0] rand_mask(input int one_in);
    logic [4:0] m;
    m = '0;
    for (int n = 0; n < 5; n++) m[n] = ($urandom_range(0, one_in - 1) == 0);
    return m;
  endfunction

  // Forget everything, as the hardware does on reset.
  task automatic model_reset();
    m_slot = 0;
    for (int n = 0; n < 5; n++) begin
      m_code[n] = 0;
      m_ovr[n]  = 1'b0;
    end
  endtask

  // One clock edge of the scheduler rules, using the inputs of that edge.
  task automatic model_step();
    int  req;
    bit  taken;
    bit  lost;
    for (int n = 0; n < 5; n++) begin
      taken = enable && (m_slot == n);
      req   = key_off_req[n] ? 3 : key_on_req[n] ? 1 : key_release_req[n] ? 2 : 0;
      lost  = 1'b0;
      if (req != 0) begin
        lost      = (m_code[n] != 0) && !taken;
        m_code[n] = req;
      end else if (taken) begin
        m_code[n] = 0;
      end
      if (OVR_EN) begin
        if (lost) m_ovr[n] = 1'b1;
        else if (overrun_clr[n]) m_ovr[n] = 1'b0;
      end
    end
    if (enable) m_slot = (m_slot + 1) % 6;
  endtask

  // Single comparison point; every check in the bench goes through here.
  task automatic checkLit(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every observable output against the model.
  task automatic checkOutput();
    checkLit("model_active",  int'(active),   m_slot);
    checkLit("model_keys",    int'(dut_keys), int'(model_keys()));
    checkLit("model_pending", int'(pending),  int'(model_pending()));
    checkLit("model_overrun", int'(overrun),  int'(model_ovr()));
  endtask

  // Drive one cycle of inputs from a negedge, let the edge happen, then
  // compare on the following negedge.
  task automatic applyStimulus(input logic en, input logic [4:0] on,
                               input logic [4:0] rel, input logic [4:0] off,
                               input logic [4:0] clr);
    enable          = en;
    key_on_req      = on;
    key_release_req = rel;
    key_off_req     = off;
    overrun_clr     = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    checkOutput();
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear
  // without waiting for a clock.
  task automatic resetPulse();
    enable          = 1'b0;
    key_on_req      = '0;
    key_release_req = '0;
    key_off_req     = '0;
    overrun_clr     = '0;
    nreset          = 1'b0;
    #2;
    model_reset();
    checkOutput();
    nreset = 1'b1;
    @(negedge clk);
  endtask

  // Directed scenarios first, then random traffic, then the summary.
  initial begin
    logic [14:0] seen_keys;
    model_reset();
    $display("[TB] start, overrun feature = %0d", OVR_EN);

    // Reset state while held in reset across clock edges.
    @(negedge clk);
    @(negedge clk);
    checkLit("reset_active",  int'(active),   0);
    checkLit("reset_keys",    int'(dut_keys), 0);
    checkLit("reset_pending", int'(pending),  0);
    checkLit("reset_overrun", int'(overrun),  0);
    nreset = 1'b1;
    @(negedge clk);

    // Slot sequence over two rounds, then hold with enable low.
    for (int i = 0; i < 12; i++) begin
      checkLit("seq_active", int'(active), i % 6);
      applyStimulus(1'b1, '0, '0, '0, '0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, '0, '0, '0);
      checkLit("hold_active", int'(active), 0);
    end

    // Key-on for channel C issued in slot 0, consumed at the slot 2 edge.
    applyStimulus(1'b1, 5'b00100, '0, '0, '0);
    checkLit("c_on_slot1",   int'(ch_c_key_on), 1);
    checkLit("c_pend_slot1", int'(pending[2]),  1);
    applyStimulus(1'b1, '0, '0, '0, '0);
    checkLit("c_on_slot2",   int'(ch_c_key_on), 1);
    applyStimulus(1'b1, '0, '0, '0, '0);
    checkLit("c_on_after",   int'(ch_c_key_on), 0);
    checkLit("c_pend_after", int'(pending[2]),  0);

    // All three requests on channel B at once: off wins.
    applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b00010, '0);
    checkLit("b_off", int'({ch_b_key_off, ch_b_key_on, ch_b_key_release}), 3'b100);

    // Channel A: on then release before its slot; release survives.
    applyStimulus(1'b1, 5'b00001, '0, '0, '0);
    applyStimulus(1'b1, '0, 5'b00001, '0, '0);
    checkLit("a_active0",  int'(active), 0);
    checkLit("a_release",  int'({ch_a_key_release, ch_a_key_on}), 2'b10);
    checkLit("a_overrun",  int'(overrun[0]), int'(OVR_EN));
    applyStimulus(1'b1, '0, '0, '0, '0);
    checkLit("a_consumed", int'(ch_a_key_release), 0);
    applyStimulus(1'b1, '0, '0, '0, 5'b00001);
    checkLit("a_ovr_clr",  int'(overrun[0]), 0);

    // Channel D: off pending, then key-on exactly on the consuming edge.
    applyStimulus(1'b1, '0, '0, 5'b01000, '0);
    checkLit("d_off_pend", int'(ch_d_key_off), 1);
    applyStimulus(1'b1, 5'b01000, '0, '0, '0);
    checkLit("d_on_new",   int'({ch_d_key_on, ch_d_key_off}), 2'b10);
    checkLit("d_no_ovr",   int'(overrun[3]), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, '0, '0, '0, '0);
    checkLit("d_on_wait",  int'(ch_d_key_on), 1);
    applyStimulus(1'b1, '0, '0, '0, '0);
    checkLit("d_on_gone",  int'(ch_d_key_on), 0);

    // Reset mid-round with events on every channel at slot 3.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, '0, '0, '0, '0);
    applyStimulus(1'b0, 5'b11111, '0, '0, '0);
    checkLit("rst_pre_active",  int'(active),  3);
    checkLit("rst_pre_pending", int'(pending), 5'b11111);
    resetPulse();
    checkLit("rst_active", int'(active),   0);
    checkLit("rst_keys",   int'(dut_keys), 0);
    seen_keys = '0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, '0, '0, '0, '0);
      seen_keys |= dut_keys;
    end
    checkLit("rst_no_replay", int'(seen_keys), 0);

    // Random traffic with occasional resets and overrun clears.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        resetPulse();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, rand_mask(9), rand_mask(9),
                      rand_mask(12), rand_mask(8));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wts_key_event_scheduler.md
WTS_KEY_EVENT_SCHEDULER -- requirements
Module: wts_key_event_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOT, default 6, meaning slots per round: 5 channel slots (0..4) plus 1 no-op slot (5).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  slot sequencer advance enable.
REQ-005 SHALL have port key_on_req  input  5  per-channel (bit0=A..bit4=E) one-cycle key-on request.
REQ-006 SHALL have port key_release_req  input  5  per-channel one-cycle key-release request.
REQ-007 SHALL have port key_off_req  input  5  per-channel one-cycle key-off request.
REQ-008 SHALL have port overrun_clr  input  5  per-channel sticky overrun clear.
REQ-009 SHALL have port active  output  3  current slot index to the envelope generator, 0..4 channel, 5 no-op.
REQ-010 SHALL have ports ch_a..ch_e _key_on/_key_release/_key_off  output  1 each  pending event level per channel.
REQ-011 SHALL have port pending  output  5  per-channel "event not yet consumed".
REQ-012 SHALL have port overrun  output  5  per-channel sticky overrun flag.

Function
REQ-013 SHALL advance active 0,1,2,3,4,5,0... by one per clk when enable=1; SHALL hold when enable=0.
REQ-014 SHALL hold per channel one pending code: NONE, ON, RELEASE, OFF; at most one of that channel's three key outputs is 1.
REQ-015 SHALL register a request: pending code updates on the edge sampling the request; output visible the next cycle (latency 1).
REQ-016 SHALL resolve simultaneous requests on one channel in the same cycle with priority OFF > ON > RELEASE.
REQ-017 SHALL let a new request overwrite an unconsumed pending code (latest wins).
REQ-018 SHALL consume a channel's event on the edge where enable=1 and active equals that channel: code becomes NONE.
REQ-019 SHALL give a request arriving on the consuming edge priority: the new code is stored; the old one is consumed.
REQ-020 SHALL keep key outputs as steady levels until consumption; never pulse them independently of active.
REQ-021 SHALL never consume on slot 5; requests during slot 5 wait for their channel slot.
REQ-022 SHALL drive pending[n]=1 iff channel n code is not NONE.
REQ-023 SHALL make a consumed event present for exactly one enabled channel-slot cycle.

Reset
REQ-024 SHALL on nreset=0 asynchronously force: active=0, all codes NONE, all key outputs 0, pending=0, overrun=0.
REQ-025 SHALL discard, on reset mid-round, all unconsumed events; no event replays after release of reset.
REQ-026 SHALL start counting from slot 0 on the first enabled edge after reset release.

Configuration
REQ-027 SHALL, with WTS_KEY_OVERRUN_EN defined, set overrun[n] when a request overwrites a non-NONE code not consumed on that edge.
REQ-028 SHALL clear overrun[n] when overrun_clr[n]=1; a set event on the same edge wins.
REQ-029 SHALL, with WTS_KEY_OVERRUN_EN undefined, tie overrun to 0, ignore overrun_clr and implement no overrun flops.

Structure
REQ-030 SHALL take from shared package wts_key_pkg: the pending-code typedef (NONE/ON/RELEASE/OFF), NUM_CH=5 and NOP_SLOT=5.
REQ-031 SHALL instantiate sub-module wts_key_event_slot five times, one per channel; it holds the code, priority, consumption and overrun logic.
REQ-032 SHALL keep the slot counter and output fan-out in the top module only.

Verification
REQ-033 SHALL cover: reset, enable=1 for 12 cycles -> active 0,1,2,3,4,5,0,1,2,3,4,5; enable=0 -> active holds.
REQ-034 SHALL cover: key_on_req=5'b00100 while active=0 -> ch_c_key_on=1 from next cycle through active=2 edge, then 0; pending[2] mirrors it.
REQ-035 SHALL cover: key_off_req[1], key_on_req[1] and key_release_req[1] in one cycle -> only ch_b_key_off=1.
REQ-036 SHALL cover: key_on_req[0] then key_release_req[0] before slot 0 -> ch_a_key_release=1 only; overrun[0]=1 with WTS_KEY_OVERRUN_EN, else 0.
REQ-037 SHALL cover: key_on_req[3] on the consuming edge of slot 3 -> ch_d_key_on stays 1 until the next slot-3 edge; overrun[3] stays 0.
REQ-038 SHALL cover: nreset pulsed with events pending at active=3 -> all outputs 0, active=0, no later event emitted.
